// File: rtl/seg_scan_sched_if.sv
// -----------------------------------------------------------------------------
// seg_scan_sched_if
//   Bundle between the SoC GPIO display registers and the seven-segment scan
//   scheduler.
//
//   Signals
//     DIG0..DIG3  [3:0]  hex value shown on digits 0..3
//     DIG_DOT     [3:0]  bit i lights the decimal point of digit i
//     DIG_ENA     [3:0]  bit i enables digit i
//     frame_sync         one-cycle pulse following each snapshot
//     seg_out     [7:0]  segment lines, bit 0..6 = a..g, bit 7 = dp
//     segcs_out   [3:0]  digit selects, bit i = digit i
//
//   Modports
//     master : GPIO side, drives digit data and observes the pin outputs
//     slave  : scheduler side, consumes digit data and drives the pins
// -----------------------------------------------------------------------------
interface seg_scan_sched_if;
    logic [3:0] DIG0;
    logic [3:0] DIG1;
    logic [3:0] DIG2;
    logic [3:0] DIG3;
    logic [3:0] DIG_DOT;
    logic [3:0] DIG_ENA;
    logic       frame_sync;
    logic [7:0] seg_out;
    logic [3:0] segcs_out;

    modport master (
        output DIG0, DIG1, DIG2, DIG3, DIG_DOT, DIG_ENA,
        input  frame_sync, seg_out, segcs_out
    );

    modport slave (
        input  DIG0, DIG1, DIG2, DIG3, DIG_DOT, DIG_ENA,
        output frame_sync, seg_out, segcs_out
    );
endinterface

// File: rtl/seg_scan_sched.sv
// -----------------------------------------------------------------------------
// seg_scan_sched
//   Time-multiplexing scheduler for a shared 4-digit seven-segment bus.
//   Once per frame the four hex nibbles plus per-digit dot and enable bits are
//   snapshotted; digits 0..3 are then scanned, each preceded by an all-off
//   BLANK slot (anti-ghosting dead time) and followed by an ON slot in which the
//   digit is lit. Frame length is fixed at 4*(BLANK_CYC+DWELL_CYC) cycles.
//
//   Parameters
//     DWELL_CYC    cycles each digit is lit (>=1)
//     BLANK_CYC    cycles of dead time before each digit (>=1)
//     SEG_ACT_LOW  1: segment lines active-low, 0: active-high
//     CS_ACT_LOW   1: digit selects active-low, 0: active-high
//
//   Ports
//     clk    system clock
//     RSTn   asynchronous active-low reset
//     bus    seg_scan_sched_if.slave (digit data in, pins/frame_sync out)
// -----------------------------------------------------------------------------
module seg_scan_sched #(
    parameter int unsigned DWELL_CYC   = 50000,
    parameter int unsigned BLANK_CYC   = 500,
    parameter bit          SEG_ACT_LOW = 1'b1,
    parameter bit          CS_ACT_LOW  = 1'b1
) (
    input  logic             clk,
    input  logic             RSTn,
    seg_scan_sched_if.slave  bus
);

    // Counter only ever has to reach the larger of the two terminal counts.
    localparam int unsigned MAX_CYC = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYC - 1);

    localparam logic [7:0] SEG_OFF = SEG_ACT_LOW ? 8'hFF : 8'h00;
    localparam logic [3:0] CS_OFF  = CS_ACT_LOW  ? 4'hF  : 4'h0;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------

    // Hex digit to segments in active-high form, bits g..a.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] val);
        logic [6:0] seg;
        case (val)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

    // Map active-high segment pattern to the pin polarity.
    function automatic logic [7:0] seg_pins(input logic [7:0] seg_ah);
        return SEG_ACT_LOW ? ~seg_ah : seg_ah;
    endfunction

    // Map active-high one-hot select to the pin polarity.
    function automatic logic [3:0] cs_pins(input logic [3:0] cs_ah);
        return CS_ACT_LOW ? ~cs_ah : cs_ah;
    endfunction

    // -------------------------------------------------------------------------
    // Declarations
    // -------------------------------------------------------------------------
    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_idx;
    logic [1:0]       w_idx_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic [3:0]       r_dig [4];
    logic [3:0]       w_dig_nxt [4];
    logic [3:0]       r_dot;
    logic [3:0]       w_dot_nxt;
    logic [3:0]       r_ena;
    logic [3:0]       w_ena_nxt;

    logic             w_snap;
    logic             r_frame_sync;
    logic [7:0]       r_seg;
    logic [7:0]       w_seg_nxt;
    logic [3:0]       r_cs;
    logic [3:0]       w_cs_nxt;

    // Start of frame: first BLANK cycle of digit 0.
    assign w_snap = (r_state == ST_BLANK) && (r_idx == 2'd0) && (r_cnt == '0);

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            r_state <= ST_BLANK;
            r_idx   <= 2'd0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt + 1'b1;
        case (r_state)
            ST_BLANK: begin
                if (r_cnt == BLANK_LAST) begin
                    w_state_nxt = ST_ON;
                    w_cnt_nxt   = '0;
                end
            end
            ST_ON: begin
                if (r_cnt == DWELL_LAST) begin
                    w_state_nxt = ST_BLANK;
                    w_idx_nxt   = r_idx + 2'd1;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_BLANK;
                w_idx_nxt   = 2'd0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Snapshot and output decode
    // Outputs are decoded from the *next* state and *next* snapshot so the pins
    // switch on the same edge the FSM enters a slot. Using the next snapshot
    // also covers BLANK_CYC=1, where the capture edge is also the edge that
    // enters digit 0's ON slot.
    // -------------------------------------------------------------------------
    always_comb begin
        w_dig_nxt = r_dig;
        w_dot_nxt = r_dot;
        w_ena_nxt = r_ena;
        if (w_snap) begin
            w_dig_nxt[0] = bus.DIG0;
            w_dig_nxt[1] = bus.DIG1;
            w_dig_nxt[2] = bus.DIG2;
            w_dig_nxt[3] = bus.DIG3;
            w_dot_nxt    = bus.DIG_DOT;
            w_ena_nxt    = bus.DIG_ENA;
        end
    end

    always_comb begin
        w_seg_nxt = SEG_OFF;
        w_cs_nxt  = CS_OFF;
        // A disabled digit leaves the bus dark but still consumes its slot.
        if ((w_state_nxt == ST_ON) && w_ena_nxt[w_idx_nxt]) begin
            w_cs_nxt  = cs_pins(4'b0001 << w_idx_nxt);
            w_seg_nxt = seg_pins({w_dot_nxt[w_idx_nxt], hex_to_seg(w_dig_nxt[w_idx_nxt])});
        end
    end

    // -------------------------------------------------------------------------
    // Snapshot and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            for (int i = 0; i < 4; i++) begin
                r_dig[i] <= 4'h0;
            end
            r_dot        <= 4'h0;
            r_ena        <= 4'h0;
            r_frame_sync <= 1'b0;
            r_seg        <= SEG_OFF;
            r_cs         <= CS_OFF;
        end else begin
            r_dig        <= w_dig_nxt;
            r_dot        <= w_dot_nxt;
            r_ena        <= w_ena_nxt;
            r_frame_sync <= w_snap;
            r_seg        <= w_seg_nxt;
            r_cs         <= w_cs_nxt;
        end
    end

    assign bus.frame_sync = r_frame_sync;
    assign bus.seg_out    = r_seg;
    assign bus.segcs_out  = r_cs;

endmodule

// File: tb/tb_seg_scan_sched.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_sched
//   Directed bench for seg_scan_sched with DWELL_CYC=4, BLANK_CYC=2, both
//   polarities active-low (24-cycle frame). A closed-form frame model computes
//   the expected pins for each cycle from its own snapshot of the driven
//   inputs; expectations are queued as each cycle is driven and popped when
//   the DUT outputs are sampled mid-cycle.
// -----------------------------------------------------------------------------
module tb_seg_scan_sched;

    localparam int DWELL = 4;
    localparam int BLANK = 2;
    localparam int SLOT  = DWELL + BLANK;
    localparam int FRAME = 4 * SLOT;

    logic clk;
    logic RSTn;

    seg_scan_sched_if bus ();

    seg_scan_sched #(
        .DWELL_CYC   (DWELL),
        .BLANK_CYC   (BLANK),
        .SEG_ACT_LOW (1'b1),
        .CS_ACT_LOW  (1'b1)
    ) dut (
        .clk  (clk),
        .RSTn (RSTn),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] seg;
        logic [3:0] cs;
        logic       fs;
        string      tag;
    } exp_t;

    exp_t q[$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Model snapshot
    logic [3:0] m_dig [4];
    logic [3:0] m_dot;
    logic [3:0] m_ena;

    task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected pins for frame position c of a running frame.
    task automatic push_model(input int c, input string tag);
        exp_t e;
        int pos, d, off;
        pos   = c % FRAME;
        d     = pos / SLOT;
        off   = pos % SLOT;
        e.seg = 8'hFF;
        e.cs  = 4'hF;
        e.fs  = (pos == 1);
        e.tag = tag;
        if (off >= BLANK && m_ena[d]) begin
            e.cs  = ~(4'b0001 << d);
            e.seg = ~{m_dot[d], HEX[m_dig[d]]};
        end
        q.push_back(e);
    endtask

    task automatic push_idle(input string tag);
        exp_t e;
        e.seg = 8'hFF;
        e.cs  = 4'hF;
        e.fs  = 1'b0;
        e.tag = tag;
        q.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (q.size() == 0) begin
            compare("queue_underflow", 32'd0, 32'd1);
        end else begin
            e = q.pop_front();
            compare({e.tag, "_seg"}, {24'd0, bus.seg_out}, {24'd0, e.seg});
            compare({e.tag, "_cs"}, {28'd0, bus.segcs_out}, {28'd0, e.cs});
            compare({e.tag, "_fs"}, {31'd0, bus.frame_sync}, {31'd0, e.fs});
            compare({e.tag, "_onehot"}, {31'd0, ($countones(~bus.segcs_out) <= 1)}, 32'd1);
        end
    endtask

    // One cycle per iteration: sample mid-cycle, then advance past the edge.
    task automatic run_cycles(input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            push_model(cyc, tag);
            pop_check();
            if ((cyc % FRAME) == 0) begin
                m_dig[0] = bus.DIG0;
                m_dig[1] = bus.DIG1;
                m_dig[2] = bus.DIG2;
                m_dig[3] = bus.DIG3;
                m_dot    = bus.DIG_DOT;
                m_ena    = bus.DIG_ENA;
            end
            cyc++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_dig[i] = 4'h0;
        m_dot = 4'h0;
        m_ena = 4'h0;
        cyc   = 0;
    endtask

    initial begin
        RSTn        = 1'b0;
        bus.DIG0    = 4'h1;
        bus.DIG1    = 4'h2;
        bus.DIG2    = 4'h3;
        bus.DIG3    = 4'h4;
        bus.DIG_DOT = 4'h0;
        bus.DIG_ENA = 4'hF;
        model_reset();

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        push_idle("reset");
        pop_check();
        @(posedge clk);
        #1;

        // Basic scan, two frames
        RSTn = 1'b1;
        run_cycles(2 * FRAME, "basic");

        // Digit 2 = 8 with its dot
        bus.DIG2    = 4'h8;
        bus.DIG_DOT = 4'b0100;
        run_cycles(FRAME, "dot8");

        // Digits 0 and 2 disabled
        bus.DIG_ENA = 4'b1010;
        run_cycles(2 * FRAME, "ena");

        // Mid-frame change of DIG0 is deferred to the next snapshot
        bus.DIG_ENA = 4'hF;
        bus.DIG_DOT = 4'h0;
        bus.DIG0    = 4'h1;
        run_cycles(FRAME, "pre_mid");
        run_cycles(10, "mid");
        bus.DIG0 = 4'h7;
        run_cycles(FRAME - 10 + FRAME, "mid");

        // Reset during digit-1 ON slot
        run_cycles(9, "pre_rst");
        RSTn = 1'b0;
        #1;
        push_idle("async_rst");
        pop_check();
        repeat (2) begin
            @(negedge clk);
            push_idle("in_rst");
            pop_check();
        end
        @(posedge clk);
        #1;
        model_reset();
        RSTn = 1'b1;
        run_cycles(2 * FRAME, "post_rst");

        // Sweep DIG0 over every hex value, one frame each
        for (int v = 0; v < 16; v++) begin
            bus.DIG0 = 4'(v);
            run_cycles(FRAME, "sweep");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
